// File: rtl/jzjpcc_fetch_control.sv
// jzjpcc_fetch_control
// Fetch-stage PC sequencing: chooses each cycle between holding the PC,
// incrementing it, or loading a redirect target. Taken branches from execute
// take priority over jumps from decode. A redirect that arrives while
// instruction memory is busy is parked in a pending register until memory can
// accept it. An ebreak halt state freezes fetch until an external resume.
//
// Optional build feature: define JZJPCC_FETCH_PERF_COUNTERS_EN to get real
// redirect and stall-cycle counters. Without it, both counter ports are tied
// to zero and no counter flops exist.

module jzjpcc_fetch_control #(
    parameter int COUNTER_WIDTH = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     hazardStall,
    input  logic                     imemReady,
    input  logic                     branchTaken,
    input  logic [31:2]              branchTarget,
    input  logic                     jumpRequest,
    input  logic [31:2]              jumpTarget,
    input  logic                     haltRequest,
    input  logic                     resume,
    output logic                     pcStall,
    output logic                     pcWriteEnable,
    output logic [31:2]              newPC,
    output logic                     flushFetch,
    output logic                     flushDecode,
    output logic                     halted,
    output logic [COUNTER_WIDTH-1:0] redirectCount,
    output logic [COUNTER_WIDTH-1:0] stallCycleCount
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_HALTED   = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_pending_valid;
    logic [31:2] r_pending_target;

    state_t      w_state_next;
    logic        w_pending_valid_next;
    logic [31:2] w_pending_target_next;

    logic        w_pc_stall;
    logic        w_pc_write_enable;
    logic [31:2] w_target;
    logic        w_flush_fetch;
    logic        w_flush_decode;
    logic        w_halted;
    logic        w_redirect;
    logic [31:2] w_redirect_target;
    logic        w_wait_target_sel;

    // Next-state and raw output decode from state, pending register and requests
    always_comb begin
        w_state_next          = r_state;
        w_pending_valid_next  = r_pending_valid;
        w_pending_target_next = r_pending_target;
        w_pc_stall            = 1'b0;
        w_pc_write_enable     = 1'b0;
        w_target              = 30'd0;
        w_flush_fetch         = 1'b0;
        w_flush_decode        = 1'b0;
        w_halted              = 1'b0;
        w_redirect            = 1'b0;
        w_redirect_target     = 30'd0;
        w_wait_target_sel     = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (haltRequest) begin
                    // ebreak wins over any redirect in the same cycle
                    w_state_next   = ST_HALTED;
                    w_pc_stall     = 1'b1;
                    w_flush_fetch  = 1'b1;
                    w_flush_decode = 1'b1;
                end else begin
                    if (branchTaken) begin
                        w_redirect        = 1'b1;
                        w_redirect_target = branchTarget;
                        w_flush_fetch     = 1'b1;
                        w_flush_decode    = 1'b1;
                    end else if (jumpRequest && !hazardStall) begin
                        w_redirect        = 1'b1;
                        w_redirect_target = jumpTarget;
                        w_flush_fetch     = 1'b1;
                    end else begin
                        w_redirect        = 1'b0;
                    end

                    if (w_redirect) begin
                        if (imemReady) begin
                            w_pc_write_enable = 1'b1;
                            w_target          = w_redirect_target;
                        end else begin
                            // Memory busy: park the target and keep fetch frozen
                            w_pc_stall            = 1'b1;
                            w_pending_valid_next  = 1'b1;
                            w_pending_target_next = w_redirect_target;
                            w_state_next          = ST_WAIT_MEM;
                        end
                    end else begin
                        w_pc_stall = hazardStall | ~imemReady;
                    end
                end
            end

            ST_WAIT_MEM: begin
                w_flush_fetch = 1'b1;
                if (haltRequest) begin
                    // Keep the parked redirect so it is applied after resume
                    w_state_next   = ST_HALTED;
                    w_pc_stall     = 1'b1;
                    w_flush_decode = 1'b1;
                end else begin
                    w_wait_target_sel = branchTaken;
                    w_flush_decode    = branchTaken;
                    if (w_wait_target_sel) begin
                        w_redirect_target = branchTarget;
                    end else begin
                        w_redirect_target = r_pending_target;
                    end

                    if (imemReady) begin
                        w_pc_write_enable    = 1'b1;
                        w_target             = w_redirect_target;
                        w_pending_valid_next = 1'b0;
                        w_state_next         = ST_RUN;
                    end else begin
                        w_pc_stall            = 1'b1;
                        w_pending_target_next = w_redirect_target;
                    end
                end
            end

            ST_HALTED: begin
                w_pc_stall    = 1'b1;
                w_flush_fetch = 1'b1;
                w_halted      = 1'b1;
                if (resume) begin
                    if (r_pending_valid) begin
                        w_state_next = ST_WAIT_MEM;
                    end else begin
                        w_state_next = ST_RUN;
                    end
                end else begin
                    w_state_next = ST_HALTED;
                end
            end

            default: begin
                // Unreachable encoding: recover to a clean running state
                w_state_next          = ST_RUN;
                w_pending_valid_next  = 1'b0;
                w_pending_target_next = 30'd0;
                w_pc_stall            = 1'b1;
                w_flush_fetch         = 1'b1;
                w_flush_decode        = 1'b1;
            end
        endcase
    end

    // State and pending-redirect registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state          <= ST_RUN;
            r_pending_valid  <= 1'b0;
            r_pending_target <= 30'd0;
        end else begin
            r_state          <= w_state_next;
            r_pending_valid  <= w_pending_valid_next;
            r_pending_target <= w_pending_target_next;
        end
    end

    // Reset forces a frozen, fully flushed pipeline; newPC is zero unless written
    assign pcStall       = reset ? 1'b1 : w_pc_stall;
    assign pcWriteEnable = reset ? 1'b0 : w_pc_write_enable;
    assign newPC         = (reset || !w_pc_write_enable) ? 30'd0 : w_target;
    assign flushFetch    = reset ? 1'b1 : w_flush_fetch;
    assign flushDecode   = reset ? 1'b1 : w_flush_decode;
    assign halted        = reset ? 1'b0 : w_halted;

`ifdef JZJPCC_FETCH_PERF_COUNTERS_EN
    localparam logic [COUNTER_WIDTH-1:0] CNT_ZERO = {COUNTER_WIDTH{1'b0}};
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE  = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};

    logic [COUNTER_WIDTH-1:0] r_redirect_count;
    logic [COUNTER_WIDTH-1:0] r_stall_cycle_count;

    // Wrapping performance counters: applied redirects and non-halt stall cycles
    always_ff @(posedge clock) begin
        if (reset) begin
            r_redirect_count    <= CNT_ZERO;
            r_stall_cycle_count <= CNT_ZERO;
        end else begin
            if (pcWriteEnable) begin
                r_redirect_count <= r_redirect_count + CNT_ONE;
            end else begin
                r_redirect_count <= r_redirect_count;
            end
            if (pcStall && !halted) begin
                r_stall_cycle_count <= r_stall_cycle_count + CNT_ONE;
            end else begin
                r_stall_cycle_count <= r_stall_cycle_count;
            end
        end
    end

    assign redirectCount   = r_redirect_count;
    assign stallCycleCount = r_stall_cycle_count;
`else
    assign redirectCount   = {COUNTER_WIDTH{1'b0}};
    assign stallCycleCount = {COUNTER_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_jzjpcc_fetch_control.sv
// Self-checking bench for jzjpcc_fetch_control: a directed vector table with
// expected outputs, hand-written PC/halt/counter sequences, and a randomized
// phase compared every cycle against a behavioural reference model.

module tb_jzjpcc_fetch_control;

    localparam int CW = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic          hazardStall;
    logic          imemReady;
    logic          branchTaken;
    logic [31:2]   branchTarget;
    logic          jumpRequest;
    logic [31:2]   jumpTarget;
    logic          haltRequest;
    logic          resume;
    logic          pcStall;
    logic          pcWriteEnable;
    logic [31:2]   newPC;
    logic          flushFetch;
    logic          flushDecode;
    logic          halted;
    logic [CW-1:0] redirectCount;
    logic [CW-1:0] stallCycleCount;

    jzjpcc_fetch_control #(.COUNTER_WIDTH(CW)) dut (
        .clock           (clock),
        .reset           (reset),
        .hazardStall     (hazardStall),
        .imemReady       (imemReady),
        .branchTaken     (branchTaken),
        .branchTarget    (branchTarget),
        .jumpRequest     (jumpRequest),
        .jumpTarget      (jumpTarget),
        .haltRequest     (haltRequest),
        .resume          (resume),
        .pcStall         (pcStall),
        .pcWriteEnable   (pcWriteEnable),
        .newPC           (newPC),
        .flushFetch      (flushFetch),
        .flushDecode     (flushDecode),
        .halted          (halted),
        .redirectCount   (redirectCount),
        .stallCycleCount (stallCycleCount)
    );

    always #5 clock = ~clock;

    // Bench-side program counter driven by the controller's outputs
    logic [29:0] tb_pc;
    always_ff @(posedge clock) begin
        if (reset)              tb_pc <= 30'd0;
        else if (pcWriteEnable) tb_pc <= newPC;
        else if (!pcStall)      tb_pc <= tb_pc + 30'd1;
        else                    tb_pc <= tb_pc;
    end

    typedef struct {
        logic        rst, hz, rdy, bt;
        logic [29:0] btg;
        logic        jr;
        logic [29:0] jtg;
        logic        hr, rs;
        logic [34:0] exp_out;   // {stall, we, newPC, flushF, flushD, halted}
    } vec_t;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: "halted" flag, parked redirect, counters
    logic        m_halt = 1'b0;
    logic        m_pv   = 1'b0;
    logic [29:0] m_pt   = 30'd0;
    logic [31:0] m_rc   = 32'd0;
    logic [31:0] m_sc   = 32'd0;

    function automatic vec_t mk(input logic rst, hz, rdy, bt, input logic [29:0] btg,
                                input logic jr, input logic [29:0] jtg, input logic hr, rs,
                                input logic st, we, input logic [29:0] pc,
                                input logic ff, fd, h);
        vec_t v;
        v.rst = rst; v.hz = hz; v.rdy = rdy; v.bt = bt; v.btg = btg;
        v.jr = jr; v.jtg = jtg; v.hr = hr; v.rs = rs;
        v.exp_out = {st, we, pc, ff, fd, h};
        return v;
    endfunction

    function automatic vec_t idle(input logic rdy);
        return mk(1'b0, 1'b0, rdy, 1'b0, 30'd0, 1'b0, 30'd0, 1'b0, 1'b0,
                  1'b0, 1'b0, 30'd0, 1'b0, 1'b0, 1'b0);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    endtask

    // Expected outputs from the fetch-control rules; advances the model one cycle
    task automatic model_step(input vec_t v, output logic [34:0] e);
        logic        st, we, ff, fd, h;
        logic [29:0] tgt;
        logic        take;
        st = 1'b0; we = 1'b0; ff = 1'b0; fd = 1'b0; h = 1'b0; tgt = 30'd0; take = 1'b0;
        if (v.rst) begin
            st = 1'b1; ff = 1'b1; fd = 1'b1;
            m_halt = 1'b0; m_pv = 1'b0; m_pt = 30'd0;
        end else if (m_halt) begin
            st = 1'b1; ff = 1'b1; h = 1'b1;
            if (v.rs) m_halt = 1'b0;
        end else if (v.hr) begin
            st = 1'b1; ff = 1'b1; fd = 1'b1; m_halt = 1'b1;
        end else begin
            if (m_pv) begin
                take = 1'b1; ff = 1'b1; fd = v.bt;
                tgt = v.bt ? v.btg : m_pt;
            end else if (v.bt) begin
                take = 1'b1; ff = 1'b1; fd = 1'b1; tgt = v.btg;
            end else if (v.jr && !v.hz) begin
                take = 1'b1; ff = 1'b1; tgt = v.jtg;
            end
            if (take && v.rdy) begin
                we = 1'b1; m_pv = 1'b0;
            end else if (take) begin
                st = 1'b1; m_pv = 1'b1; m_pt = tgt;
            end else begin
                st = v.hz || !v.rdy;
            end
        end
        e = {st, we, (we ? tgt : 30'd0), ff, fd, h};
        if (v.rst) begin
            m_rc = 32'd0; m_sc = 32'd0;
        end else begin
            m_rc = m_rc + {31'd0, we};
            m_sc = m_sc + {31'd0, st && !h};
        end
    endtask

    // Drive one cycle's inputs, check counters and outputs against the model
    task automatic cycle(input vec_t v, output logic [34:0] act);
        logic [34:0] e;
        logic [31:0] erc, esc;
        @(negedge clock);
        reset = v.rst; hazardStall = v.hz; imemReady = v.rdy;
        branchTaken = v.bt; branchTarget = v.btg;
        jumpRequest = v.jr; jumpTarget = v.jtg;
        haltRequest = v.hr; resume = v.rs;
        #1;
`ifdef JZJPCC_FETCH_PERF_COUNTERS_EN
        erc = m_rc; esc = m_sc;
`else
        erc = 32'd0; esc = 32'd0;
`endif
        check("counters", {redirectCount, stallCycleCount}, {erc, esc});
        model_step(v, e);
        act = {pcStall, pcWriteEnable, newPC, flushFetch, flushDecode, halted};
        check("model", {29'd0, act}, {29'd0, e});
    endtask

    vec_t        tbl[$];
    logic [34:0] act;
    logic [29:0] frozen;

    initial begin
        reset = 1'b1; hazardStall = 1'b0; imemReady = 1'b1; branchTaken = 1'b0;
        branchTarget = 30'd0; jumpRequest = 1'b0; jumpTarget = 30'd0;
        haltRequest = 1'b0; resume = 1'b0;

        //            rst   hz    rdy   bt    btg      jr    jtg      hr    rs    st    we    pc       ff    fd    h
        tbl.push_back(mk(1'b1,1'b0,1'b1,1'b0,30'h0, 1'b0,30'h0, 1'b0,1'b0, 1'b1,1'b0,30'h0, 1'b1,1'b1,1'b0));
        tbl.push_back(mk(1'b1,1'b0,1'b1,1'b0,30'h0, 1'b0,30'h0, 1'b0,1'b0, 1'b1,1'b0,30'h0, 1'b1,1'b1,1'b0));
        tbl.push_back(idle(1'b1));
        tbl.push_back(mk(1'b0,1'b1,1'b1,1'b1,30'h40,1'b1,30'h80,1'b0,1'b0, 1'b0,1'b1,30'h40,1'b1,1'b1,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,30'h0, 1'b1,30'h10,1'b0,1'b0, 1'b1,1'b0,30'h0, 1'b1,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,30'h0, 1'b1,30'h10,1'b0,1'b0, 1'b1,1'b0,30'h0, 1'b1,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,30'h0, 1'b1,30'h10,1'b0,1'b0, 1'b1,1'b0,30'h0, 1'b1,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b1,1'b0,30'h0, 1'b0,30'h0, 1'b0,1'b0, 1'b0,1'b1,30'h10,1'b1,1'b0,1'b0));
        tbl.push_back(idle(1'b1));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,30'h0, 1'b1,30'h10,1'b0,1'b0, 1'b1,1'b0,30'h0, 1'b1,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b1,1'b1,30'h20,1'b0,30'h0, 1'b0,1'b0, 1'b0,1'b1,30'h20,1'b1,1'b1,1'b0));
        tbl.push_back(idle(1'b1));
        tbl.push_back(mk(1'b0,1'b0,1'b1,1'b0,30'h0, 1'b0,30'h0, 1'b1,1'b0, 1'b1,1'b0,30'h0, 1'b1,1'b1,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b1,1'b0,30'h0, 1'b0,30'h0, 1'b0,1'b0, 1'b1,1'b0,30'h0, 1'b1,1'b0,1'b1));
        tbl.push_back(mk(1'b0,1'b0,1'b1,1'b1,30'h55,1'b1,30'h66,1'b0,1'b0, 1'b1,1'b0,30'h0, 1'b1,1'b0,1'b1));
        tbl.push_back(mk(1'b0,1'b0,1'b1,1'b0,30'h0, 1'b0,30'h0, 1'b1,1'b1, 1'b1,1'b0,30'h0, 1'b1,1'b0,1'b1));
        tbl.push_back(idle(1'b1));
        tbl.push_back(mk(1'b0,1'b1,1'b1,1'b0,30'h0, 1'b0,30'h0, 1'b0,1'b0, 1'b1,1'b0,30'h0, 1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b1,1'b1,1'b0,30'h0, 1'b1,30'h33,1'b0,1'b0, 1'b1,1'b0,30'h0, 1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b1,1'b0,30'h0, 1'b1,30'h33,1'b0,1'b0, 1'b0,1'b1,30'h33,1'b1,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,30'h0, 1'b0,30'h0, 1'b0,1'b0, 1'b1,1'b0,30'h0, 1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,30'h0, 1'b1,30'h7, 1'b0,1'b0, 1'b1,1'b0,30'h0, 1'b1,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,30'h0, 1'b0,30'h0, 1'b1,1'b0, 1'b1,1'b0,30'h0, 1'b1,1'b1,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,30'h0, 1'b0,30'h0, 1'b0,1'b1, 1'b1,1'b0,30'h0, 1'b1,1'b0,1'b1));
        tbl.push_back(mk(1'b0,1'b0,1'b1,1'b0,30'h0, 1'b0,30'h0, 1'b0,1'b0, 1'b0,1'b1,30'h7, 1'b1,1'b0,1'b0));
        tbl.push_back(idle(1'b1));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,30'h0, 1'b1,30'h9, 1'b0,1'b0, 1'b1,1'b0,30'h0, 1'b1,1'b0,1'b0));
        tbl.push_back(mk(1'b1,1'b0,1'b1,1'b0,30'h0, 1'b0,30'h0, 1'b0,1'b0, 1'b1,1'b0,30'h0, 1'b1,1'b1,1'b0));
        tbl.push_back(idle(1'b1));

        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i], act);
            check($sformatf("vec%0d", i), {29'd0, act}, {29'd0, tbl[i].exp_out});
        end

        // PC counts 0,1,2,3 after reset release
        cycle(mk(1'b1,1'b0,1'b1,1'b0,30'h0,1'b0,30'h0,1'b0,1'b0,1'b1,1'b0,30'h0,1'b1,1'b1,1'b0), act);
        cycle(mk(1'b1,1'b0,1'b1,1'b0,30'h0,1'b0,30'h0,1'b0,1'b0,1'b1,1'b0,30'h0,1'b1,1'b1,1'b0), act);
        for (int i = 0; i < 4; i++) begin
            cycle(idle(1'b1), act);
            check("pc_seq", {34'd0, tb_pc}, {34'd0, 30'(i)});
        end

        // Halt freezes the PC for 5 cycles, resume lets it count again
        cycle(mk(1'b0,1'b0,1'b1,1'b0,30'h0,1'b0,30'h0,1'b1,1'b0,1'b1,1'b0,30'h0,1'b1,1'b1,1'b0), act);
        frozen = tb_pc;
        for (int i = 0; i < 5; i++) begin
            cycle(idle(1'b1), act);
            check("halt_pc", {34'd0, tb_pc}, {34'd0, frozen});
            check("halted", {63'd0, halted}, 64'd1);
        end
        cycle(mk(1'b0,1'b0,1'b1,1'b0,30'h0,1'b0,30'h0,1'b0,1'b1,1'b1,1'b0,30'h0,1'b1,1'b0,1'b1), act);
        cycle(idle(1'b1), act);
        check("resume_pc0", {34'd0, tb_pc}, {34'd0, frozen});
        cycle(idle(1'b1), act);
        check("resume_pc1", {34'd0, tb_pc}, {34'd0, frozen + 30'd1});

        // Counters: 2 redirects then 3 hazard stalls, then reset clears them
        cycle(mk(1'b1,1'b0,1'b1,1'b0,30'h0,1'b0,30'h0,1'b0,1'b0,1'b1,1'b0,30'h0,1'b1,1'b1,1'b0), act);
        cycle(mk(1'b0,1'b0,1'b1,1'b1,30'h100,1'b0,30'h0,1'b0,1'b0,1'b0,1'b1,30'h100,1'b1,1'b1,1'b0), act);
        cycle(mk(1'b0,1'b0,1'b1,1'b0,30'h0,1'b1,30'h200,1'b0,1'b0,1'b0,1'b1,30'h200,1'b1,1'b0,1'b0), act);
        for (int i = 0; i < 3; i++)
            cycle(mk(1'b0,1'b1,1'b1,1'b0,30'h0,1'b0,30'h0,1'b0,1'b0,1'b1,1'b0,30'h0,1'b0,1'b0,1'b0), act);
        cycle(idle(1'b1), act);
`ifdef JZJPCC_FETCH_PERF_COUNTERS_EN
        check("cnt_2_3", {redirectCount, stallCycleCount}, {32'd2, 32'd3});
`else
        check("cnt_tied", {redirectCount, stallCycleCount}, 64'd0);
`endif
        cycle(mk(1'b1,1'b0,1'b1,1'b0,30'h0,1'b0,30'h0,1'b0,1'b0,1'b1,1'b0,30'h0,1'b1,1'b1,1'b0), act);
        cycle(idle(1'b1), act);
        check("cnt_reset", {redirectCount, stallCycleCount}, 64'd0);

        // Randomized phase against the reference model
        for (int i = 0; i < 3000; i++) begin
            vec_t v;
            v = mk(($urandom_range(63) == 0), ($urandom_range(3) == 0), ($urandom_range(3) != 0),
                   ($urandom_range(7) == 0), 30'($urandom), ($urandom_range(5) == 0), 30'($urandom),
                   ($urandom_range(31) == 0), ($urandom_range(3) == 0),
                   1'b0, 1'b0, 30'd0, 1'b0, 1'b0, 1'b0);
            cycle(v, act);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
